// File: rtl/life_scan_ctrl_if.sv
// Scan-port bundle between the Life scan controller and the cell array.
// The controller drives the chain shift/write and the step pulse, and the array returns the head cell.
interface life_scan_ctrl_if;
    logic scan;
    logic scan_write_val;
    logic scan_write_enb;
    logic scan_read_val;
    logic run;

    modport master (
        output scan,
        output scan_write_val,
        output scan_write_enb,
        output run,
        input  scan_read_val
    );

    modport slave (
        input  scan,
        input  scan_write_val,
        input  scan_write_enb,
        input  run,
        output scan_read_val
    );
endinterface

// File: rtl/life_scan_ctrl.sv
// Life array scan-chain master: per frame, reads (recirculating) or loads every cell,
// publishes a whole-array alive snapshot, then optionally issues one generation step.
module life_scan_ctrl #(
    parameter int CELLS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame,
    input  logic                 step_enb,
    input  logic                 load_req,
    input  logic [CELLS-1:0]     load_pattern,
    output logic                 load_ack,
    life_scan_ctrl_if.master     arr,
    output logic [CELLS-1:0]     alive,
    output logic                 alive_valid,
    output logic                 busy,
    output logic                 overrun
);

    localparam int CW = $clog2(CELLS);
    localparam logic [CW-1:0] LAST = CW'(CELLS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, STEP} state_t;

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     count;
    logic              mode;
    logic [CELLS-1:0]  pat;
    logic [CELLS-2:0]  shadow;
    logic              new_bit;
    logic              last;
    logic              scan_on;
    logic              run_reg;

    always_comb begin
        state_next = state;
        scan_on    = 1'b0;
        last       = (count == LAST);
        new_bit    = mode ? pat[count] : arr.scan_read_val;
        case (state)
            IDLE: if (frame) state_next = SCAN;
            SCAN: begin
                scan_on = 1'b1;
                if (last) state_next = (!mode && step_enb) ? STEP : IDLE;
            end
            STEP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign arr.scan           = scan_on;
    assign arr.scan_write_enb = scan_on;
    assign arr.scan_write_val = new_bit;
    assign arr.run            = run_reg;
    assign busy               = (state != IDLE);

    // The final cell goes straight into alive alongside the shadow, so alive only ever
    // changes as a complete snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            mode        <= 1'b0;
            pat         <= '0;
            shadow      <= '0;
            alive       <= '0;
            alive_valid <= 1'b0;
            load_ack    <= 1'b0;
            run_reg     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_next;
            alive_valid <= 1'b0;
            load_ack    <= 1'b0;
            run_reg     <= 1'b0;
            if (frame && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (frame) begin
                        count <= '0;
                        mode  <= load_req;
                        pat   <= load_pattern;
                    end
                end
                SCAN: begin
                    count <= count + 1'b1;
                    if (!last) begin
                        shadow[count] <= new_bit;
                    end else begin
                        alive       <= {new_bit, shadow};
                        alive_valid <= 1'b1;
                        load_ack    <= mode;
                        run_reg     <= !mode && step_enb;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
